// File: rtl/pipe_buf_if.sv
// pipe_buf_if: stage handshake bundle between an upstream writer, a downstream reader and pipe_buf.
interface pipe_buf_if #(
    parameter int DATA_W = 160,
    parameter int DEPTH  = 2
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              flush;
    logic              up_we;
    logic [DATA_W-1:0] up_din;
    logic              up_wack;
    logic              up_full;
    logic              buf_avail;
    logic              buf_re;
    logic              buf_rack;
    logic [DATA_W-1:0] dout;
    logic [CW-1:0]     count;
    modport master (
        output flush, up_we, up_din, buf_re,
        input  up_wack, up_full, buf_avail, buf_rack, dout, count
    );
    modport slave (
        input  flush, up_we, up_din, buf_re,
        output up_wack, up_full, buf_avail, buf_rack, dout, count
    );
endinterface

// File: rtl/pipe_buf.sv
// pipe_buf: inter-stage FIFO with level-request/one-cycle-ack handshakes and flush.
// Define PIPE_BUF_BYPASS_EN to let an empty buffer pass a same-cycle write straight to dout.
module pipe_buf #(
    parameter int DATA_W = 160,
    parameter int DEPTH  = 2
) (
    input logic       clk_i,
    input logic       rst_ni,
    pipe_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wack_q, wack_d, rack_q, rack_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              full, avail, wr_ok, rd_ok, byp, we, re;
    assign full  = count_q == CW'(DEPTH);
    assign avail = count_q != '0;
    // an ack already in flight masks its port so a held level request is taken once
    assign wr_ok = bus.up_we && !full && !wack_q && !bus.flush;
    assign rd_ok = bus.buf_re && avail && !rack_q && !bus.flush;
`ifdef PIPE_BUF_BYPASS_EN
    assign byp = !avail && bus.up_we && !wack_q && bus.buf_re && !rack_q && !bus.flush;
`else
    assign byp = 1'b0;
`endif
    assign we = wr_ok && !byp;
    assign re = rd_ok;
    always_comb begin
        wack_d  = wr_ok;
        rack_d  = rd_ok || byp;
        dout_d  = byp ? bus.up_din : rd_ok ? mem_q[rptr_q] : dout_q;
        count_d = bus.flush ? '0 : count_q + CW'(we) - CW'(re);
        wptr_d  = bus.flush ? '0 : wptr_q + PW'(we);
        rptr_d  = bus.flush ? '0 : rptr_q + PW'(re);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            wack_q  <= 1'b0;
            rack_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            wack_q  <= wack_d;
            rack_q  <= rack_d;
            dout_q  <= dout_d;
        end
    end
    // storage is deliberately left out of reset
    always_ff @(posedge clk_i) begin
        if (we) mem_q[wptr_q] <= bus.up_din;
    end
    assign bus.up_wack   = wack_q;
    assign bus.buf_rack  = rack_q;
    assign bus.dout      = dout_q;
    assign bus.count     = count_q;
    assign bus.up_full   = full;
    assign bus.buf_avail = avail;
endmodule
